// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Program-sequencing stage upstream of the control decoder. Holds the PC,
//   presents the current instruction word and its opcode field, and computes
//   the next PC (sequential, beq, j). A start/done handshake runs one program
//   from a given start address until it halts. Counts retired instructions.
//
// Ports
//   clk          in   clock, all state updates on the rising edge
//   reset        in   synchronous, active-high
//   start        in   one-cycle pulse, honoured only in IDLE or DONE
//   startAddr    in   PC loaded on an accepted start
//   romData      in   instruction ROM read data for address pc
//   branch       in   branch/jump request for the current instruction
//   zero         in   ALU equality result (beq condition)
//   targetAddr   in   absolute branch/jump target
//   pc           out  current PC, drives the ROM address
//   instruction  out  current instruction word (romData pass-through)
//   opcode       out  top 3 bits of the instruction
//   instrValid   out  high only while running
//   done         out  high once the program has halted
//   instrCount   out  instructions retired since the last accepted start
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter int PC_WIDTH    = 10,
  parameter int INSTR_WIDTH = 9,
  parameter int PROG_LEN    = 1024,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [PC_WIDTH-1:0]    startAddr,
  input  logic [INSTR_WIDTH-1:0] romData,
  input  logic                   branch,
  input  logic                   zero,
  input  logic [PC_WIDTH-1:0]    targetAddr,
  output logic [PC_WIDTH-1:0]    pc,
  output logic [INSTR_WIDTH-1:0] instruction,
  output logic [2:0]             opcode,
  output logic                   instrValid,
  output logic                   done,
  output logic [CNT_WIDTH-1:0]   instrCount
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [2:0]          OP_BEQ  = 3'b001;
  localparam logic [2:0]          OP_J    = 3'b111;
  localparam logic [PC_WIDTH-1:0] LAST_PC = PC_WIDTH'(PROG_LEN - 1);

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [PC_WIDTH-1:0]    r_pc;
  logic [PC_WIDTH-1:0]    w_pc_nxt;
  logic [CNT_WIDTH-1:0]   r_count;
  logic [CNT_WIDTH-1:0]   w_count_nxt;
  logic [2:0]             w_opcode;
  logic                   w_taken;
  logic                   w_halt;

  assign w_opcode = romData[INSTR_WIDTH-1 -: 3];

  // branch with any opcode other than j/beq is ignored, so the request only
  // counts when qualified by the opcode of the instruction actually retiring.
  assign w_taken = branch && ((w_opcode == OP_J) || ((w_opcode == OP_BEQ) && zero));

  // A taken branch overrides the end-of-program halt: only a self-loop stops
  // it. Without a taken branch the program ends when the last PC retires.
  assign w_halt = w_taken ? (targetAddr == r_pc) : (r_pc == LAST_PC);

  // NOTE: every signal written here gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_count_nxt = r_count;
    unique case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_state_nxt = S_RUN;
          w_pc_nxt    = startAddr;
          w_count_nxt = '0;
        end
      end
      S_RUN: begin
        // The halting instruction still retires, so the count always moves.
        if (!(&r_count)) begin
          w_count_nxt = r_count + CNT_WIDTH'(1);
        end
        if (w_halt) begin
          w_state_nxt = S_DONE;
        end else if (w_taken) begin
          w_pc_nxt = targetAddr;
        end else begin
          w_pc_nxt = r_pc + PC_WIDTH'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_pc    <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_count <= w_count_nxt;
    end
  end

  assign pc          = r_pc;
  assign instruction = romData;
  assign opcode      = w_opcode;
  assign instrValid  = (r_state == S_RUN);
  assign done        = (r_state == S_DONE);
  assign instrCount  = r_count;

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//   Two fetch_unit instances share all stimulus and one ROM image:
//     dut_a : PC_WIDTH=4, PROG_LEN=8,  CNT_WIDTH=16
//     dut_b : PC_WIDTH=4, PROG_LEN=16, CNT_WIDTH=4 (counter saturates at 15)
//   Each is compared every cycle against an abstract program-execution model,
//   plus a vector table and hand-written corner-case sequences.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

  localparam int PCW = 4;
  localparam int IW  = 9;

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic [PCW-1:0] startAddr;
  logic           branch;
  logic           zero;
  logic [PCW-1:0] targetAddr;
  logic [IW-1:0]  rom [16];

  logic [PCW-1:0] pc_a, pc_b;
  logic [IW-1:0]  rom_a, rom_b, instr_a, instr_b;
  logic [2:0]     op_a, op_b;
  logic           valid_a, valid_b, done_a, done_b;
  logic [15:0]    cnt_a;
  logic [3:0]     cnt_b;

  assign rom_a = rom[pc_a];
  assign rom_b = rom[pc_b];

  always #5 clk = ~clk;

  fetch_unit #(.PC_WIDTH(PCW), .INSTR_WIDTH(IW), .PROG_LEN(8), .CNT_WIDTH(16)) dut_a (
    .clk(clk), .reset(reset), .start(start), .startAddr(startAddr),
    .romData(rom_a), .branch(branch), .zero(zero), .targetAddr(targetAddr),
    .pc(pc_a), .instruction(instr_a), .opcode(op_a), .instrValid(valid_a),
    .done(done_a), .instrCount(cnt_a)
  );

  fetch_unit #(.PC_WIDTH(PCW), .INSTR_WIDTH(IW), .PROG_LEN(16), .CNT_WIDTH(4)) dut_b (
    .clk(clk), .reset(reset), .start(start), .startAddr(startAddr),
    .romData(rom_b), .branch(branch), .zero(zero), .targetAddr(targetAddr),
    .pc(pc_b), .instruction(instr_b), .opcode(op_b), .instrValid(valid_b),
    .done(done_b), .instrCount(cnt_b)
  );

  // Abstract program state: mode 0 = idle, 1 = running, 2 = finished.
  typedef struct {
    int mode;
    int pc;
    int cnt;
  } model_t;

  typedef struct {
    bit rst;
    bit st;
    int saddr;
    int exp_pc;
    bit exp_valid;
    bit exp_done;
    int exp_cnt;
  } vec_t;

  model_t m_a, m_b;
  int     checks = 0;
  int     errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One instruction per cycle: a taken j/beq goes to the target, everything
  // else to pc+1 (mod 16); the program stops on a self-loop or when the last
  // address retires without a taken branch.
  function automatic model_t model_step(model_t m, int last, int cmax);
    model_t n = m;
    int     op;
    bit     taken;
    if (reset) begin
      n.mode = 0; n.pc = 0; n.cnt = 0;
      return n;
    end
    if (m.mode != 1) begin
      if (start) begin
        n.mode = 1; n.pc = int'(startAddr); n.cnt = 0;
      end
      return n;
    end
    op    = int'(rom[m.pc][IW-1 -: 3]);
    taken = branch && (op == 7 || (op == 1 && zero));
    n.cnt = (m.cnt + 1 > cmax) ? cmax : m.cnt + 1;
    if ((taken && int'(targetAddr) == m.pc) || (!taken && m.pc == last))
      n.mode = 2;
    else if (taken)
      n.pc = int'(targetAddr);
    else
      n.pc = (m.pc + 1) % 16;
    return n;
  endfunction

  task automatic compare_models();
    check("a.pc",    32'(pc_a),    32'(m_a.pc));
    check("a.valid", 32'(valid_a), 32'(m_a.mode == 1));
    check("a.done",  32'(done_a),  32'(m_a.mode == 2));
    check("a.cnt",   32'(cnt_a),   32'(m_a.cnt));
    check("a.instr", 32'(instr_a), 32'(rom[m_a.pc]));
    check("a.op",    32'(op_a),    32'(rom[m_a.pc][IW-1 -: 3]));
    check("b.pc",    32'(pc_b),    32'(m_b.pc));
    check("b.valid", 32'(valid_b), 32'(m_b.mode == 1));
    check("b.done",  32'(done_b),  32'(m_b.mode == 2));
    check("b.cnt",   32'(cnt_b),   32'(m_b.cnt));
    check("b.op",    32'(op_b),    32'(rom[m_b.pc][IW-1 -: 3]));
  endtask

  // Advance the models with the currently applied inputs, clock once, then
  // sample 1 ns after the edge.
  task automatic step();
    m_a = model_step(m_a, 7, 65535);
    m_b = model_step(m_b, 15, 15);
    @(posedge clk);
    #1;
    compare_models();
  endtask

  task automatic restart(input int addr);
    reset = 1'b1; start = 1'b0; branch = 1'b0; zero = 1'b0;
    step();
    reset = 1'b0; start = 1'b1; startAddr = PCW'(addr);
    step();
    start = 1'b0;
  endtask

  vec_t vecs [8];

  initial begin
    reset = 1'b1; start = 1'b0; startAddr = '0;
    branch = 1'b0; zero = 1'b0; targetAddr = '0;
    m_a = '{0, 0, 0};
    m_b = '{0, 0, 0};
    for (int i = 0; i < 16; i++) rom[i] = '0;  // all xor

    // ---- table: start at 5, sequential run to the end of dut_a's program
    vecs[0] = '{1, 0, 0, 0, 0, 0, 0};
    vecs[1] = '{0, 1, 5, 5, 1, 0, 0};
    vecs[2] = '{0, 0, 0, 6, 1, 0, 1};
    vecs[3] = '{0, 0, 0, 7, 1, 0, 2};
    vecs[4] = '{0, 0, 0, 7, 0, 1, 3};
    vecs[5] = '{0, 0, 0, 7, 0, 1, 3};
    vecs[6] = '{0, 1, 0, 0, 1, 0, 0};
    vecs[7] = '{0, 0, 0, 1, 1, 0, 1};
    for (int i = 0; i < 8; i++) begin
      reset = vecs[i].rst; start = vecs[i].st; startAddr = PCW'(vecs[i].saddr);
      step();
      check($sformatf("vec%0d.pc", i),    32'(pc_a),    32'(vecs[i].exp_pc));
      check($sformatf("vec%0d.valid", i), 32'(valid_a), 32'(vecs[i].exp_valid));
      check($sformatf("vec%0d.done", i),  32'(done_a),  32'(vecs[i].exp_done));
      check($sformatf("vec%0d.cnt", i),   32'(cnt_a),   32'(vecs[i].exp_cnt));
    end

    // ---- beq taken / not taken at pc=2
    rom[2] = 9'b001_000101;
    restart(2);
    check("beq.start_pc", 32'(pc_a), 32'd2);
    branch = 1'b1; zero = 1'b1; targetAddr = 4'd10;
    step();
    check("beq.taken_pc", 32'(pc_a), 32'd10);
    check("beq.taken_cnt", 32'(cnt_a), 32'd1);
    restart(2);
    branch = 1'b1; zero = 1'b0; targetAddr = 4'd10;
    step();
    check("beq.not_taken_pc", 32'(pc_a), 32'd3);
    branch = 1'b0;

    // ---- j self-loop halts with the jump counted
    rom[4] = 9'b111_000000;
    restart(4);
    branch = 1'b1; targetAddr = 4'd4;
    step();
    check("jself.done", 32'(done_a), 32'd1);
    check("jself.valid", 32'(valid_a), 32'd0);
    check("jself.pc", 32'(pc_a), 32'd4);
    check("jself.cnt", 32'(cnt_a), 32'd1);
    branch = 1'b0;
    step();
    check("jself.hold_pc", 32'(pc_a), 32'd4);

    // ---- start during RUN is ignored
    restart(0);
    step();
    start = 1'b1; startAddr = 4'd6;
    step();
    start = 1'b0;
    check("runstart.pc", 32'(pc_a), 32'd2);
    repeat (6) step();
    check("runstart.done", 32'(done_a), 32'd1);
    check("runstart.cnt", 32'(cnt_a), 32'd8);

    // ---- dut_b: taken j at last PC does not halt, wraps, halts on return
    rom[15] = 9'b111_000011;
    restart(15);
    branch = 1'b1; targetAddr = 4'd0;
    step();
    check("wrap.j_pc", 32'(pc_b), 32'd0);
    check("wrap.j_done", 32'(done_b), 32'd0);
    branch = 1'b0;
    repeat (15) step();
    check("wrap.at_last", 32'(pc_b), 32'd15);
    check("wrap.still_running", 32'(valid_b), 32'd1);
    step();
    check("wrap.done", 32'(done_b), 32'd1);
    check("wrap.pc_held", 32'(pc_b), 32'd15);
    check("wrap.cnt_sat", 32'(cnt_b), 32'd15);

    // ---- reset together with start mid-RUN
    restart(5);
    step();
    check("rstrun.pc6", 32'(pc_a), 32'd6);
    reset = 1'b1; start = 1'b1; startAddr = 4'd3;
    step();
    check("rstrun.pc", 32'(pc_a), 32'd0);
    check("rstrun.cnt", 32'(cnt_a), 32'd0);
    check("rstrun.done", 32'(done_a), 32'd0);
    check("rstrun.valid", 32'(valid_a), 32'd0);
    reset = 1'b0; start = 1'b0;

    // ---- randomized run against the models
    for (int i = 0; i < 16; i++) begin
      case ($urandom_range(3))
        0:       rom[i] = {3'b001, 6'($urandom)};
        1:       rom[i] = {3'b111, 6'($urandom)};
        2:       rom[i] = {3'b000, 6'($urandom)};
        default: rom[i] = 9'($urandom);
      endcase
    end
    restart(0);
    for (int i = 0; i < 600; i++) begin
      reset      = ($urandom_range(49) == 0);
      start      = ($urandom_range(7) == 0);
      startAddr  = PCW'($urandom);
      branch     = $urandom_range(1) == 1;
      zero       = $urandom_range(1) == 1;
      targetAddr = PCW'($urandom);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Program-sequencing stage directly upstream of the control decoder. Holds the program counter, presents the current instruction word and its 3-bit opcode field to the decoder, and computes the next PC from sequential increment, conditional branch (beq) or unconditional jump (j). A start/done handshake with the testbench or host runs one program from a given start address to completion. Also counts retired instructions.

## Interface
- PC_WIDTH, 10, program counter / instruction ROM address width
- INSTR_WIDTH, 9, instruction word width; opcode is bits [INSTR_WIDTH-1 -: 3]
- PROG_LEN, 1024, last legal PC is PROG_LEN-1; must be ≤ 2^PC_WIDTH
- CNT_WIDTH, 16, retired-instruction counter width

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle pulse; honoured only in IDLE or DONE
- startAddr  in  PC_WIDTH  PC loaded on accepted start
- romData  in  INSTR_WIDTH  instruction ROM read data for address pc (combinational ROM)
- branch  in  1  branch/jump request from control decoder for the current instruction
- zero  in  1  ALU equality result for the current instruction (beq condition)
- targetAddr  in  PC_WIDTH  absolute branch/jump target (from target lookup)
- pc  out  PC_WIDTH  current PC; drives ROM address
- instruction  out  INSTR_WIDTH  current instruction word to decoder/register file
- opcode  out  3  instruction[INSTR_WIDTH-1 -: 3]; feeds decoder instruction input
- instrValid  out  1  high only in RUN; downstream gates regWrite/memWrite with it
- done  out  1  high in DONE
- instrCount  out  CNT_WIDTH  instructions retired since last accepted start

## Operation
- States: IDLE, RUN, DONE.
- IDLE: instrValid=0, pc held. start → pc←startAddr, instrCount←0, state←RUN.
- RUN: each cycle one instruction retires (instrValid=1); instrCount increments (saturates at all-ones).
- Next PC in RUN:
  - opcode 3'b111 (j) with branch=1 → targetAddr.
  - opcode 3'b001 (beq) with branch=1 and zero=1 → targetAddr.
  - otherwise → pc+1, modulo 2^PC_WIDTH.
- Halt conditions (checked on retiring instruction, that instruction still counts):
  - pc == PROG_LEN-1 and no taken branch → state←DONE, pc held.
  - taken branch/jump with targetAddr == pc (self-loop) → state←DONE, pc held.
  - A taken branch at pc == PROG_LEN-1 to another address does not halt.
- DONE: done=1, instrValid=0, pc and instrCount held. start → same as from IDLE (done drops next cycle).
- start during RUN ignored. branch asserted with any other opcode ignored (sequential).
- instruction = romData, opcode = its top 3 bits, passed through combinationally in all states.

## Timing
- Reset (synchronous, dominates start): state=IDLE, pc=0, instrCount=0, done=0, instrValid=0.
- Reset mid-RUN: next edge returns to IDLE, counter cleared; no partial behaviour.
- start sampled at edge N → pc=startAddr and instrValid=1 from cycle N+1.
- Single-cycle fetch: instruction at pc retires in the cycle it is presented; next PC visible after the following edge. Zero branch penalty.
- Halt: instruction retiring in cycle M → done=1, instrValid=0 from cycle M+1.
- instrCount updates on the same edge as pc; value after halt equals number of retired instructions including the halting one.

## Test plan
- Reset then start with startAddr=5, ROM all xor (3'b000), PROG_LEN=8 → pc 5,6,7; done high after pc=7 retires; instrCount=3; pc holds 7.
- beq at pc=2, branch=1, zero=1, targetAddr=10 → next pc=10; repeat with zero=0 → next pc=3.
- j at pc=4, branch=1, targetAddr=4 → done next cycle, instrCount includes the jump; pc stays 4.
- start pulsed during RUN → ignored, sequence unaffected; start in DONE with startAddr=0 → done falls, pc=0, instrCount restarts at 0.
- PC_WIDTH=4, PROG_LEN=16, start at 15 with taken j to 0 then sequential run → no halt at 15 on the jump, wraps correctly, halts on second arrival at 15.
- reset asserted in RUN at pc=6 together with start → IDLE, pc=0, instrCount=0, done=0, instrValid=0 next cycle.
